// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops a byte whenever the FIFO is non-empty and enabled, then
// shifts it out as an asynchronous UART frame (start, data LSB first, optional even parity, stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);

  logic [2:0]            state_reg;
  logic [BAUD_W-1:0]     baud_cnt_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic                  stop_cnt_reg;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  parity_reg;
  logic                  tx_reg;
  logic                  frame_done_reg;
  logic                  baud_end;
  logic [DATA_WIDTH:0]   par_chain;

  // Even parity of the word being popped, folded bit by bit.
  assign par_chain[0] = 1'b0;
  genvar gi;
  generate
    for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_par
      assign par_chain[gi+1] = par_chain[gi] ^ fifo_data[gi];
    end
  endgenerate

  // Mealy pop strobe; gated by rst so nothing is popped while held in reset.
  assign fifo_rd    = (state_reg == IDLE) & enable & ~fifo_empty & ~rst;
  assign baud_end   = (baud_cnt_reg == BAUD_LAST);
  assign tx         = tx_reg;
  assign busy       = (state_reg != IDLE);
  assign frame_done = frame_done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      baud_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      stop_cnt_reg   <= 1'b0;
      shift_reg      <= '0;
      parity_reg     <= 1'b0;
      tx_reg         <= 1'b1;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (fifo_rd) begin
            shift_reg    <= fifo_data;
            parity_reg   <= par_chain[DATA_WIDTH];
            tx_reg       <= 1'b0;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            stop_cnt_reg <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            tx_reg       <= shift_reg[0];
            state_reg    <= DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            shift_reg    <= shift_reg >> 1;
            if (bit_cnt_reg == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_reg    <= parity_reg;
                state_reg <= PARITY;
              end else begin
                tx_reg    <= 1'b1;
                state_reg <= STOP;
              end
            end else begin
              // tx is registered, so present the next bit as this one ends.
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              tx_reg      <= shift_reg[1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            state_reg    <= STOP;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        STOP: begin
          if (baud_end) begin
            baud_cnt_reg <= '0;
            if ((STOP_BITS == 1) || (stop_cnt_reg == 1'b1)) begin
              frame_done_reg <= 1'b1;
              state_reg      <= IDLE;
            end else begin
              stop_cnt_reg <= 1'b1;
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 1'b1;
          end
        end
        default: begin
          tx_reg    <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
